// File: rtl/read_frame_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : read_frame_collector_if
// Description : Sample stream, PS read port and interrupt bundle for the
//               read frame collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface read_frame_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  read_start_intr;
    logic                  rd_bank;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_done;
    logic [15:0]           frame_cnt;

    modport slave (
        input  s_valid, s_data, rd_en, rd_addr, rd_done,
        output s_ready, read_start_intr, rd_bank, rd_data, frame_cnt
    );

    modport master (
        output s_valid, s_data, rd_en, rd_addr, rd_done,
        input  s_ready, read_start_intr, rd_bank, rd_data, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/read_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : read_frame_collector
// Description : Ping-pong frame buffer that raises read_start_intr per full
//               bank, serves PS reads and recycles banks on rd_done.
// Revision    : 1.0 - initial release
// ============================================================================
module read_frame_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int MIN_GAP    = 24
) (
    input  wire logic               clk,
    input  wire logic               rst,
    read_frame_collector_if.slave   bus
);

    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int GAP_WIDTH = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [GAP_WIDTH-1:0]  GAP_LOAD  = GAP_WIDTH'(MIN_GAP);
    localparam logic [ADDR_WIDTH:0]   ADDR_LIM  = (ADDR_WIDTH + 1)'(FRAME_LEN);

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_BUSY = 1'b1;

    logic [DATA_WIDTH-1:0] mem_q [2][FRAME_LEN];

    logic                  wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [1:0]            full_q, full_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [0:0]            rd_state_q, rd_state_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic                  read_start_intr_q, read_start_intr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    logic                  s_ready_w;
    logic                  xfer_w;
    logic                  rd_in_range_w;

    assign s_ready_w     = !rst && !full_q[wr_bank_q];
    assign xfer_w        = bus.s_valid && s_ready_w;
    assign rd_in_range_w = ({1'b0, bus.rd_addr} < ADDR_LIM);

    always_comb begin
        wr_bank_d         = wr_bank_q;
        wr_cnt_d          = wr_cnt_q;
        full_d            = full_q;
        rd_bank_d         = rd_bank_q;
        rd_state_d        = rd_state_q;
        gap_cnt_d         = gap_cnt_q;
        read_start_intr_d = 1'b0;
        rd_data_d         = rd_data_q;
        frame_cnt_d       = frame_cnt_q;

        if (xfer_w) begin
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_cnt_d          = '0;
                wr_bank_d         = !wr_bank_q;
                frame_cnt_d       = frame_cnt_q + 16'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + IDX_W'(1);
            end
        end

        if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end

        // The released bank is never the one being committed, so both edits to full_d stand.
        case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q] && (gap_cnt_q == '0)) begin
                    read_start_intr_d = 1'b1;
                    gap_cnt_d         = GAP_LOAD;
                    rd_state_d        = RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (bus.rd_done) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    rd_state_d        = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        if (bus.rd_en) begin
            rd_data_d = rd_in_range_w ? mem_q[rd_bank_q][bus.rd_addr[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q         <= 1'b0;
            wr_cnt_q          <= '0;
            full_q            <= 2'b00;
            rd_bank_q         <= 1'b0;
            rd_state_q        <= RD_IDLE;
            gap_cnt_q         <= '0;
            read_start_intr_q <= 1'b0;
            rd_data_q         <= '0;
            frame_cnt_q       <= 16'd0;
        end else begin
            wr_bank_q         <= wr_bank_d;
            wr_cnt_q          <= wr_cnt_d;
            full_q            <= full_d;
            rd_bank_q         <= rd_bank_d;
            rd_state_q        <= rd_state_d;
            gap_cnt_q         <= gap_cnt_d;
            read_start_intr_q <= read_start_intr_d;
            rd_data_q         <= rd_data_d;
            frame_cnt_q       <= frame_cnt_d;
        end
    end

    // Sample storage carries no reset; stale contents are never presented as a new frame.
    always_ff @(posedge clk) begin
        if (xfer_w) begin
            mem_q[wr_bank_q][wr_cnt_q] <= bus.s_data;
        end
    end

    assign bus.s_ready         = s_ready_w;
    assign bus.read_start_intr = read_start_intr_q;
    assign bus.rd_bank         = rd_bank_q;
    assign bus.rd_data         = rd_data_q;
    assign bus.frame_cnt       = frame_cnt_q;

endmodule
`default_nettype wire
